// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer driving register-file and ALU bus controls.
// Optional macro BR_ZERO_EN: makes BR conditional on z_flag (falls through with done when z_flag=0).
module control_unit #(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3,
    parameter int ARG_NUM  = 2,
    localparam int IW      = OP_SIZE + ARG_NUM * ARG_SIZE,
    localparam int NREG    = 1 << ARG_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [IW-1:0]       instruction,
    input  logic                din_valid,
    input  logic                z_flag,
    output logic [NREG-1:0]     r_in,
    output logic [NREG-1:0]     r_out,
    output logic                din_out,
    output logic                a_in,
    output logic                g_in,
    output logic                g_out,
    output logic                alu_xor,
    output logic                done,
    output logic                branch,
    output logic [ARG_SIZE:0]   branchaddress,
    output logic                busy
);

    localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(4'b0000);
    localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(4'b0001);
    localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'b0010);
    localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4'b0011);
    localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(4'b1000);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t                state;
    logic [IW-1:0]         ir;
    logic [OP_SIZE-1:0]    op;
    logic [ARG_SIZE-1:0]   dst;
    logic [ARG_SIZE-1:0]   src;
    logic                  regs_ok;

    // Code 0 (no register) and the all-ones code (PC) are not bus registers.
    function automatic logic reg_ok(input logic [ARG_SIZE-1:0] code);
        return (code != '0) && (code != '1);
    endfunction

    function automatic logic [NREG-1:0] sel(input logic [ARG_SIZE-1:0] code);
        return NREG'(1) << code;
    endfunction

    assign op      = ir[IW-1 -: OP_SIZE];
    assign dst     = ir[2*ARG_SIZE-1 -: ARG_SIZE];
    assign src     = ir[ARG_SIZE-1:0];
    assign regs_ok = reg_ok(dst) && reg_ok(src);

`ifndef BR_ZERO_EN
    wire unused_z_flag = z_flag;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: if (run) begin
                    ir    <= instruction;
                    state <= T1;
                end
                T1: begin
                    case (op)
                        OP_LOAD:        if (din_valid) state <= T0;
                        OP_ADD, OP_XOR: state <= regs_ok ? T2 : T0;
                        default:        state <= T0;
                    endcase
                end
                T2: state <= T3;
                T3: state <= T0;
            endcase
        end
    end

    always_comb begin
        r_in          = '0;
        r_out         = '0;
        din_out       = 1'b0;
        a_in          = 1'b0;
        g_in          = 1'b0;
        g_out         = 1'b0;
        alu_xor       = 1'b0;
        done          = 1'b0;
        branch        = 1'b0;
        branchaddress = '0;
        busy          = (state != T0);
        case (state)
            T0: ;
            T1: begin
                case (op)
                    OP_MOVE: begin
                        done = 1'b1;
                        if (regs_ok) begin
                            r_out = sel(src);
                            r_in  = sel(dst);
                        end
                    end
                    // LOAD stalls silently until the external bus has data.
                    OP_LOAD: if (din_valid) begin
                        done    = 1'b1;
                        din_out = 1'b1;
                        if (reg_ok(dst)) r_in = sel(dst);
                    end
                    OP_ADD, OP_XOR: begin
                        if (regs_ok) begin
                            r_out = sel(dst);
                            a_in  = 1'b1;
                        end else begin
                            done = 1'b1;
                        end
                    end
                    OP_BR: begin
`ifdef BR_ZERO_EN
                        if (z_flag) begin
                            branch        = 1'b1;
                            branchaddress = {dst[0], src};
                        end else begin
                            done = 1'b1;
                        end
`else
                        branch        = 1'b1;
                        branchaddress = {dst[0], src};
`endif
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                r_out   = sel(src);
                g_in    = 1'b1;
                alu_xor = (op == OP_XOR);
            end
            T3: begin
                g_out = 1'b1;
                r_in  = sel(dst);
                done  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [9:0] instruction = '0;
    logic       din_valid = 1'b0;
    logic       z_flag = 1'b0;
    logic [7:0] r_in, r_out;
    logic       din_out, a_in, g_in, g_out, alu_xor, done, branch, busy;
    logic [3:0] branchaddress;

    int total = 0;
    int bad   = 0;
    logic [27:0] exp;

    control_unit dut (
        .clk(clk), .rst(rst), .run(run), .instruction(instruction),
        .din_valid(din_valid), .z_flag(z_flag), .r_in(r_in), .r_out(r_out),
        .din_out(din_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
        .alu_xor(alu_xor), .done(done), .branch(branch),
        .branchaddress(branchaddress), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [27:0] obs = {r_in, r_out, din_out, a_in, g_in, g_out, alu_xor,
                       done, branch, branchaddress, busy};

    function automatic logic [27:0] e(input logic [7:0] ri, input logic [7:0] ro,
                                      input logic dn, input logic ai, input logic gi,
                                      input logic go, input logic ax, input logic dd,
                                      input logic br, input logic [3:0] ba, input logic bz);
        return {ri, ro, dn, ai, gi, go, ax, dd, br, ba, bz};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b1;
        instruction = 10'b0001_010_011;
        #1;
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs, exp); end
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_held got=%h exp=%h", obs, exp); end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_move();
        instruction = 10'b0001_010_011;
        run = 1'b1;
        tick();
        run = 1'b0;
        exp = e(8'h04, 8'h08, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL move_t1 got=%h exp=%h", obs, exp); end
        tick();
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL move_end got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_alu(input logic is_xor);
        instruction = {3'b001, is_xor, 6'b001_010};
        run = 1'b1;
        tick();
        run = 1'b0;
        exp = e(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL alu_t1 xor=%0d got=%h exp=%h", is_xor, obs, exp); end
        tick();
        exp = e(8'h00, 8'h04, 0, 0, 1, 0, is_xor, 0, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL alu_t2 xor=%0d got=%h exp=%h", is_xor, obs, exp); end
        tick();
        exp = e(8'h02, 8'h00, 0, 0, 0, 1, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL alu_t3 xor=%0d got=%h exp=%h", is_xor, obs, exp); end
        tick();
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL alu_end xor=%0d got=%h exp=%h", is_xor, obs, exp); end
    endtask

    task automatic test_load();
        instruction = 10'b0000_001_000;
        din_valid = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL load_stall%0d got=%h exp=%h", i, obs, exp); end
            if (i < 2) tick();
        end
        din_valid = 1'b1;
        #1;
        exp = e(8'h02, 8'h00, 1, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL load_go got=%h exp=%h", obs, exp); end
        tick();
        din_valid = 1'b0;
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL load_end got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_branch(input logic [9:0] ins, input logic zf, input logic [3:0] ba);
        instruction = ins;
        z_flag = zf;
        run = 1'b1;
        tick();
        run = 1'b0;
`ifdef BR_ZERO_EN
        if (zf) exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, ba, 1);
        else    exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
`else
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, ba, 1);
`endif
        total++;
        if (obs !== exp) begin bad++; $display("FAIL branch ins=%b z=%0d got=%h exp=%h", ins, zf, obs, exp); end
        tick();
        z_flag = 1'b0;
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL branch_end got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_nop(input logic [9:0] ins);
        instruction = ins;
        run = 1'b1;
        tick();
        run = 1'b0;
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL nop ins=%b got=%h exp=%h", ins, obs, exp); end
        tick();
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL nop_end ins=%b got=%h exp=%h", ins, obs, exp); end
    endtask

    task automatic test_back_to_back();
        instruction = 10'b0001_001_010;
        run = 1'b1;
        tick();
        exp = e(8'h02, 8'h04, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_first got=%h exp=%h", obs, exp); end
        instruction = 10'b0001_011_100;
        tick();
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_fetch got=%h exp=%h", obs, exp); end
        tick();
        run = 1'b0;
        exp = e(8'h08, 8'h10, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_second got=%h exp=%h", obs, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        instruction = 10'b0010_001_010;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        exp = e(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_t2 got=%h exp=%h", obs, exp); end
        #1;
        rst = 1'b1;
        #1;
        exp = e(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_rst_now got=%h exp=%h", obs, exp); end
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_rst_held got=%h exp=%h", obs, exp); end
        @(negedge clk);
        rst = 1'b0;
        instruction = 10'b0001_010_011;
        run = 1'b1;
        tick();
        run = 1'b0;
        exp = e(8'h04, 8'h08, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_refetch got=%h exp=%h", obs, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_move();
        test_alu(1'b0);
        test_alu(1'b1);
        test_load();
        test_branch(10'b1000_001_101, 1'b0, 4'hD);
        test_branch(10'b1000_110_010, 1'b1, 4'h2);
        test_nop(10'b0001_111_001);
        test_nop(10'b0101_011_100);
        test_nop(10'b0010_011_000);
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle controller directly downstream of the instruction ROM/PC stage.
- Latches the `{op, argA, argB}` instruction the ROM presents and sequences register-file and ALU bus controls over 2–4 cycles.
- Closes the loop back to the ROM: pulses `done` to advance the PC, or `branch` plus `branchaddress` to redirect it.
- Opcodes: LOAD=0000, MOVE=0001, ADD=0010, XOR=0011, BR=1000.
- Register codes: 0=NA, 1–6=R1–R6, 7=PC.

Parameters:
- OP_SIZE, 4, opcode field width.
- ARG_SIZE, 3, width of each argument field.
- ARG_NUM, 2, number of argument fields. Instruction width IW = OP_SIZE + ARG_NUM*ARG_SIZE = 10.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  permits fetch of a new instruction in T0.
- instruction  in  IW  from ROM; `[9:6]`=op, `[5:3]`=argA (dest), `[2:0]`=argB (src).
- din_valid  in  1  external data bus valid, used by LOAD.
- z_flag  in  1  ALU zero flag; used only when BR_ZERO_EN is defined.
- r_in  out  8  one-hot register write enable, indexed by register code.
- r_out  out  8  one-hot register bus drive, indexed by register code.
- din_out  out  1  drive external data onto the bus.
- a_in  out  1  load ALU operand register A from the bus.
- g_in  out  1  load ALU result register G.
- g_out  out  1  drive G onto the bus.
- alu_xor  out  1  ALU function: 0=add, 1=xor. Valid while g_in=1.
- done  out  1  one-cycle pulse; ROM increments PC on this edge.
- branch  out  1  one-cycle pulse; ROM loads `branchaddress` on this edge.
- branchaddress  out  4  branch target; valid while branch=1, 0 otherwise.
- busy  out  1  high when state != T0.

Behaviour:
- **State and outputs.**
  - State register holds T0, T1, T2, T3; IR register is IW bits.
  - All outputs are combinational decodes of state, IR and din_valid.
  - Any output not asserted by the rules below is 0.
- **Reset.** rst=1 forces state=T0 and IR=0 immediately (asynchronous). All outputs are 0 while rst is high and in T0.
- **T0 (fetch).**
  - No outputs are asserted.
  - If run=1: IR<=instruction, go to T1. Otherwise stay in T0 and do not update IR.
- **T1, by IR opcode:**
  - MOVE: r_out[src]=1, r_in[dst]=1, done=1, go to T0. Total 2 cycles.
  - LOAD:
    - If din_valid=0: stay in T1 with no outputs asserted (stall for any number of cycles).
    - If din_valid=1: din_out=1, r_in[dst]=1, done=1, go to T0.
  - ADD or XOR: r_out[dst]=1, a_in=1, go to T2.
  - BR: branch=1, branchaddress={argA[0], argB}, done=0, go to T0.
  - Any other opcode: done=1, go to T0. No bus activity (NOP).
- **T2 (ADD/XOR only):** r_out[src]=1, g_in=1, alu_xor=(op==XOR), go to T3.
- **T3 (ADD/XOR only):** g_out=1, r_in[dst]=1, done=1, go to T0. Total 4 cycles.
- **Illegal register operands.**
  - For MOVE, ADD or XOR: if dst ∈ {0,7} or src ∈ {0,7}, the instruction executes as NOP in T1 (done=1, no r_in/r_out).
  - For LOAD: if dst ∈ {0,7}, still wait for din_valid, then pulse done with no r_in; argB is ignored.
- **Invariants:**
  - r_in and r_out never have more than one bit set.
  - r_in[0], r_in[7], r_out[0] and r_out[7] are never asserted.
  - done and branch are never asserted in the same cycle.
- **Timing relative to the ROM.**
  - Because the PC updates on the edge that ends the final state, the next T0 samples the new ROM word.
  - run=0 during execution does not abort the current instruction; it only blocks the next fetch.
- **Reset mid-instruction.** The operation is abandoned, no done or branch is produced, and fetch restarts from T0.

Optional Feature:
- Macro: BR_ZERO_EN.
- Defined: BR is conditional. In T1, if z_flag=1, assert branch as above. If z_flag=0, assert done=1 with branch=0 (fall through). Either way go to T0.
- Undefined: BR is unconditional and z_flag is ignored.

Test Plan:
- Reset, then run=1 with instruction={0001,010,011} (MOVE R2,R3):
  - T1 shows r_out=8'b0000_1000, r_in=8'b0000_0100, done=1.
  - busy is high for exactly 1 cycle.
- ADD R1,R2 = {0010,001,010}:
  - T1: r_out=8'h02 and a_in=1.
  - T2: r_out=8'h04, g_in=1, alu_xor=0.
  - T3: g_out=1, r_in=8'h02, done=1.
  - Repeat with XOR: alu_xor=1 in T2.
- LOAD R1 = {0000,001,000}, din_valid held 0 for 3 cycles then 1:
  - 3 stall cycles with no outputs asserted.
  - Then din_out=1, r_in=8'h02, done=1 in the same cycle.
- BR with argA=001, argB=101:
  - branch=1, branchaddress=4'hD, done=0 for one cycle.
  - With BR_ZERO_EN and z_flag=0: done=1, branch=0 instead.
- Illegal operand MOVE R7,R1 and opcode 0101: each gives a single done pulse in T1 with r_in=r_out=0.
- Async reset asserted during T2 of an ADD: outputs go to 0 immediately, no done; after release, run=1 re-fetches in T0.
